// File: rtl/c17_misr_analyzer_if.sv
// c17_misr_analyzer_if: run control, C17 response handshake and result bundle for the MISR analyzer
interface c17_misr_analyzer_if #(
    parameter int SIG_W = 16
);
    logic             start;
    logic             G6gat;
    logic             G7gat;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, G6gat, G7gat, valid,
        input  ready, busy, done, pass, timeout, signature
    );

    modport slave (
        input  start, G6gat, G7gat, valid,
        output ready, busy, done, pass, timeout, signature
    );
endinterface

// File: rtl/c17_misr_analyzer.sv
// c17_misr_analyzer: MISR compaction of C17 responses with golden-signature compare.
// Optional RUN watchdog enabled by defining C17_MISR_TIMEOUT_EN.
module c17_misr_analyzer #(
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = 16'h1021,
    parameter logic [SIG_W-1:0] SEED       = '0,
    parameter int               N_PATTERNS = 32,
    parameter logic [SIG_W-1:0] GOLDEN     = '0,
    parameter int               TIMEOUT    = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    c17_misr_analyzer_if.slave  bus
);
    localparam int              CNT_W = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           r_state;
    logic [SIG_W-1:0] r_misr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic             w_xfer;
    logic             w_wd_hit;
    logic [SIG_W-1:0] w_misr_nxt;

    assign w_xfer     = bus.valid & r_ready;
    assign w_misr_nxt = {r_misr[SIG_W-2:0], 1'b0} ^ (r_misr[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'({bus.G7gat, bus.G6gat});

`ifdef C17_MISR_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd;

    // counts consecutive idle RUN cycles; any transfer or leaving RUN clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd <= '0;
        else
            r_wd <= (r_state == RUN && !w_xfer) ? r_wd + 1'b1 : '0;
    end

    assign w_wd_hit = r_state == RUN && !w_xfer && r_wd == WD_LAST;
`else
    assign w_wd_hit = 1'b0 & |TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_misr    <= SEED;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state   <= RUN;
                        r_misr    <= SEED;
                        r_cnt     <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_misr <= w_misr_nxt;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= CHECK;
                            r_ready <= 1'b0;
                        end
                    end else if (w_wd_hit) begin
                        r_state   <= DONE;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= r_misr == GOLDEN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.timeout   = r_timeout;
    assign bus.signature = r_misr;
endmodule

// File: tb/tb_c17_misr_analyzer.sv
// tb_c17_misr_analyzer: scoreboard bench; dut A = 2-pattern run (SEED 0, GOLDEN 0),
// dut B = 32-pattern C17 exhaustive run with SEED 0x8000.
module tb_c17_misr_analyzer;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] qa_sig[$];
    logic [15:0] qb_sig[$];
    logic [17:0] qa_end[$];
    logic [17:0] qb_end[$];
    logic        pa_done = 1'b0;
    logic        pb_done = 1'b0;
    logic        xa;
    logic        xb;
    logic [15:0] m;
    logic [1:0]  r;

    always #5 clk = ~clk;

    c17_misr_analyzer_if #(.SIG_W(16)) a_if ();
    c17_misr_analyzer_if #(.SIG_W(16)) b_if ();

    c17_misr_analyzer #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .N_PATTERNS(2),
                        .GOLDEN(16'h0000), .TIMEOUT(8))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

    c17_misr_analyzer #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h8000), .N_PATTERNS(32),
                        .GOLDEN(16'h0000), .TIMEOUT(64))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s, input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'h0, d};
    endfunction

    // x = C17 inputs {G7,G6,G3,G2,G1}; returns {G23, G22} as {G7gat, G6gat}
    function automatic logic [1:0] c17(input logic [4:0] x);
        logic g10, g11, g16, g19;
        g10 = ~(x[0] & x[2]);
        g11 = ~(x[2] & x[3]);
        g16 = ~(x[1] & g11);
        g19 = ~(g11 & x[4]);
        return {~(g16 & g19), ~(g10 & g16)};
    endfunction

    always @(posedge clk) begin
        xa = a_if.valid & a_if.ready;
        #1;
        if (xa) begin
            chk("a_xfer_expected", qa_sig.size() != 0, 1);
            if (qa_sig.size() != 0) chk("a_sig", a_if.signature, qa_sig.pop_front());
        end
        if (a_if.done && !pa_done) begin
            chk("a_done_expected", qa_end.size() != 0, 1);
            if (qa_end.size() != 0)
                chk("a_end_pass_to_sig", {a_if.pass, a_if.timeout, a_if.signature}, qa_end.pop_front());
        end
        pa_done = a_if.done;
    end

    always @(posedge clk) begin
        xb = b_if.valid & b_if.ready;
        #1;
        if (xb) begin
            chk("b_xfer_expected", qb_sig.size() != 0, 1);
            if (qb_sig.size() != 0) chk("b_sig", b_if.signature, qb_sig.pop_front());
        end
        if (b_if.done && !pb_done) begin
            chk("b_done_expected", qb_end.size() != 0, 1);
            if (qb_end.size() != 0)
                chk("b_end_pass_to_sig", {b_if.pass, b_if.timeout, b_if.signature}, qb_end.pop_front());
        end
        pb_done = b_if.done;
    end

    initial begin
        {a_if.start, a_if.valid, a_if.G6gat, a_if.G7gat} = 4'b0;
        {b_if.start, b_if.valid, b_if.G6gat, b_if.G7gat} = 4'b0;
        repeat (2) @(negedge clk);
        chk("a_reset", {a_if.ready, a_if.busy, a_if.done, a_if.pass, a_if.timeout, a_if.signature}, {5'b0, 16'h0000});
        chk("b_reset", {b_if.ready, b_if.busy, b_if.done, b_if.pass, b_if.timeout, b_if.signature}, {5'b0, 16'h8000});
        rst_n = 1'b1;

        // A pass run: valid alongside start in IDLE must be dropped
        @(negedge clk);
        a_if.start = 1'b1;
        a_if.valid = 1'b1;
        a_if.G6gat = 1'b1;
        @(negedge clk);
        chk("a_start", {a_if.ready, a_if.busy, a_if.signature}, {2'b11, 16'h0000});
        a_if.start = 1'b0;
        qa_sig.push_back(16'h0001);
        @(negedge clk);
        a_if.G6gat = 1'b0;
        a_if.G7gat = 1'b1;
        qa_sig.push_back(16'h0000);
        qa_end.push_back({2'b10, 16'h0000});
        @(negedge clk);
        chk("a_check_state", {a_if.ready, a_if.busy, a_if.done}, 3'b010);
        @(negedge clk);
        chk("a_done_state", {a_if.ready, a_if.busy, a_if.done, a_if.pass}, 4'b0011);
        @(negedge clk);
        a_if.valid = 1'b0;

        // A fail run: restart from DONE
        a_if.start = 1'b1;
        @(negedge clk);
        chk("a_restart", {a_if.busy, a_if.done, a_if.pass, a_if.signature}, {3'b100, 16'h0000});
        a_if.start = 1'b0;
        a_if.valid = 1'b1;
        a_if.G6gat = 1'b1;
        a_if.G7gat = 1'b0;
        qa_sig.push_back(16'h0001);
        @(negedge clk);
        qa_sig.push_back(16'h0003);
        qa_end.push_back({2'b00, 16'h0003});
        @(negedge clk);
        a_if.valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_fail_done", {a_if.done, a_if.pass, a_if.signature}, {2'b10, 16'h0003});

        // B: exhaustive C17 responses with gaps; start mid-run ignored
        m = 16'h8000;
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r = c17(i[4:0]);
            b_if.valid = 1'b1;
            {b_if.G7gat, b_if.G6gat} = r;
            b_if.start = (i == 10);
            qb_sig.push_back(i == 0 ? 16'h1021 : step(m, r));
            m = step(m, r);
            @(negedge clk);
            if (i % 3 == 2) begin
                b_if.valid = 1'b0;
                b_if.start = 1'b0;
                {b_if.G7gat, b_if.G6gat} = ~r;
                @(negedge clk);
            end
        end
        qb_end.push_back({m == 16'h0000, 1'b0, m});
        b_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_done_hold", {b_if.done, b_if.busy, b_if.signature}, {2'b10, m});
        b_if.valid = 1'b0;

        // mid-run reset on A, B sitting in DONE
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        a_if.valid = 1'b1;
        a_if.G6gat = 1'b1;
        a_if.G7gat = 1'b1;
        qa_sig.push_back(16'h0003);
        @(negedge clk);
        a_if.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("a_midrun_reset", {a_if.ready, a_if.busy, a_if.done, a_if.pass, a_if.timeout, a_if.signature}, {5'b0, 16'h0000});
        chk("b_done_reset", {b_if.ready, b_if.busy, b_if.done, b_if.pass, b_if.timeout, b_if.signature}, {5'b0, 16'h8000});
        @(negedge clk);
        rst_n = 1'b1;

`ifdef C17_MISR_TIMEOUT_EN
        // watchdog: transfer on the 7th RUN edge, then 8 idle cycles
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (6) @(negedge clk);
        a_if.valid = 1'b1;
        qa_sig.push_back(16'h0003);
        qa_end.push_back({2'b01, 16'h0003});
        @(negedge clk);
        a_if.valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("a_wd_not_yet", {a_if.done, a_if.timeout, a_if.ready}, 3'b001);
        @(negedge clk);
        chk("a_wd_fired", {a_if.done, a_if.timeout, a_if.pass, a_if.busy, a_if.ready}, 5'b11000);
`endif

        repeat (3) @(negedge clk);
        chk("a_queues_drained", qa_sig.size() + qa_end.size(), 0);
        chk("b_queues_drained", qb_sig.size() + qb_end.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
